// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rd_packer_if : FIFO read port + packed valid/ready output stream      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fifo_rd_packer_if #(
  parameter int DW_R = 32,
  parameter int PACK = 2
);
  localparam int c_cw = $clog2(PACK + 1);

  logic                   fifo_r_req;
  logic [DW_R-1:0]        fifo_data;
  logic                   fifo_empty;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW_R*PACK-1:0]   out_data;
  logic [c_cw-1:0]        out_words;

  // master: the packer itself; slave: the FIFO / downstream environment
  modport master (
    output fifo_r_req, out_valid, out_data, out_words,
    input  fifo_data, fifo_empty, flush, out_ready
  );

  modport slave (
    input  fifo_r_req, out_valid, out_data, out_words,
    output fifo_data, fifo_empty, flush, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rd_packer : drains a FIFO read port and packs PACK words per beat     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_rd_packer #(
  parameter int DW_R = 32,
  parameter int PACK = 2
) (
  input  wire              clk,
  input  wire              rst_n,
  fifo_rd_packer_if.master bus
);
  localparam int c_cw = $clog2(PACK + 1);

  logic                      r_req_en;
  logic                      r_inflight;
  logic [1:0]                r_skid_cnt;
  logic [DW_R-1:0]           r_skid [2];
  logic [c_cw-1:0]           r_cnt;
  logic [PACK-1:0][DW_R-1:0] r_acc;
  logic                      r_out_valid;
  logic [c_cw-1:0]           r_out_words;
  logic                      r_flush_pend;

  logic                      w_hs;
  logic                      w_pop;
  logic                      w_req;
  logic                      w_resolve;
  logic                      w_full;
  logic [2:0]                w_occ;
  logic [1:0]                w_skid_cnt_nxt;
  logic [DW_R-1:0]           w_skid_nxt [2];
  logic [c_cw-1:0]           w_cnt_nxt;
  logic [c_cw-1:0]           w_slot;
  logic [PACK-1:0][DW_R-1:0] w_acc_nxt;

  assign w_hs      = r_out_valid && bus.out_ready;
  assign w_pop     = (r_skid_cnt != 2'd0) && (!r_out_valid || bus.out_ready);
  // Words already committed (in flight or buffered) after this cycle's pop
  assign w_occ     = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_req     = r_req_en && !bus.fifo_empty && !r_flush_pend && (w_occ < 3'd2);
  assign w_resolve = r_flush_pend && !r_inflight && (r_skid_cnt == 2'd0) && !r_out_valid;
  assign w_slot    = w_hs ? '0 : r_cnt;

  always_comb begin
    w_skid_nxt     = r_skid;
    w_skid_cnt_nxt = r_skid_cnt;
    if (w_pop) begin
      w_skid_nxt[0]  = r_skid[1];
      w_skid_cnt_nxt = r_skid_cnt - 2'd1;
    end
    if (r_inflight) begin
      if (w_skid_cnt_nxt == 2'd0) begin
        w_skid_nxt[0] = bus.fifo_data;
      end else begin
        w_skid_nxt[1] = bus.fifo_data;
      end
      w_skid_cnt_nxt = w_skid_cnt_nxt + 2'd1;
    end
  end

  // A handshake clears the beat first so a same-cycle pop lands in slot 0
  always_comb begin
    w_cnt_nxt = w_hs ? '0 : r_cnt;
    w_acc_nxt = w_hs ? '0 : r_acc;
    if (w_pop) begin
      w_cnt_nxt = w_cnt_nxt + c_cw'(1);
      for (int i = 0; i < PACK; i++) begin
        if (w_slot == c_cw'(i)) begin
          w_acc_nxt[i] = r_skid[0];
        end
      end
    end
    w_full = (w_cnt_nxt == c_cw'(PACK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_en     <= 1'b0;
      r_inflight   <= 1'b0;
      r_skid_cnt   <= 2'd0;
      r_skid[0]    <= '0;
      r_skid[1]    <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_words  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_req_en   <= 1'b1;
      r_inflight <= w_req;
      r_skid_cnt <= w_skid_cnt_nxt;
      r_skid     <= w_skid_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      if (w_full) begin
        r_out_valid <= 1'b1;
        r_out_words <= c_cw'(PACK);
      end else if (w_resolve && (r_cnt != '0)) begin
        r_out_valid <= 1'b1;
        r_out_words <= r_cnt;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
        r_out_words <= '0;
      end
      if (w_resolve) begin
        r_flush_pend <= 1'b0;
      end else if (bus.flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  assign bus.fifo_r_req = w_req;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_acc;
  assign bus.out_words  = r_out_words;
endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// Bench for fifo_rd_packer: directed table, hand-written corner sequences and
// randomized traffic scored against a word-stream chunking model.
module tb_fifo_rd_packer;
  localparam int DW_R = 32;
  localparam int PACK = 2;
  localparam int CW   = $clog2(PACK + 1);
  localparam int BW   = DW_R * PACK;

  typedef struct { int nwords; bit flush; int exp_beats; int exp_last_words; } vec_t;
  typedef struct { logic [BW-1:0] data; logic [CW-1:0] words; } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_packer_if #(.DW_R(DW_R), .PACK(PACK)) bus ();
  fifo_rd_packer #(.DW_R(DW_R), .PACK(PACK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // FIFO model: one-cycle read latency, garbage on data when not reading
  logic [DW_R-1:0] mem [0:4095];
  int   wr_ptr      = 0;
  int   rd_ptr      = 0;
  int   bad_req     = 0;
  logic force_empty = 1'b0;
  assign bus.fifo_empty = force_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_r_req && !bus.fifo_empty) begin
      bus.fifo_data <= mem[rd_ptr[11:0]];
      rd_ptr        <= rd_ptr + 1;
    end else begin
      if (bus.fifo_r_req) bad_req <= bad_req + 1;
      bus.fifo_data <= $urandom;
    end
  end

  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          req_cnt = 0;
  beat_t       got[$];
  int          hs_cyc[$];
  int          req_cyc[$];
  logic        prev_stall = 1'b0;
  logic [BW-1:0] prev_data;
  logic [CW-1:0] prev_words;
  vec_t        tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(prev_data));
        check("hold_words", 64'(bus.out_words), 64'(prev_words));
      end
      if (bus.out_valid)
        check("words_range", 64'((bus.out_words >= 1) && (bus.out_words <= PACK)), 64'd1);
      if (bus.fifo_r_req) begin
        req_cnt++;
        req_cyc.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(beat_t'{bus.out_data, bus.out_words});
        hs_cyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_words = bus.out_words;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [DW_R-1:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr++;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  // Reference: words read since base, chunked PACK at a time; a trailing
  // partial chunk is a beat only when a flush closed the sequence.
  task automatic score(input string name, input int base, input bit flushed);
    int n;
    int nb;
    int k;
    logic [BW-1:0] ed;
    n  = rd_ptr - base;
    nb = flushed ? (n + PACK - 1) / PACK : n / PACK;
    check({name, "_nbeats"}, 64'(got.size()), 64'(nb));
    for (int b = 0; b < nb && b < got.size(); b++) begin
      k  = (n - b * PACK < PACK) ? n - b * PACK : PACK;
      ed = '0;
      for (int j = 0; j < k; j++) ed[j*DW_R +: DW_R] = mem[(base + b * PACK + j) % 4096];
      check({name, "_data"}, 64'(got[b].data), 64'(ed));
      check({name, "_words"}, 64'(got[b].words), 64'(k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r0;
    int t0;
    int bad;
    int p;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tbl[0] = '{4, 1'b0, 2, 2};
    tbl[1] = '{3, 1'b1, 2, 1};
    tbl[2] = '{5, 1'b1, 3, 1};
    tbl[3] = '{1, 1'b1, 1, 1};
    tbl[4] = '{0, 1'b1, 0, 0};
    tbl[5] = '{6, 1'b0, 3, 2};
    tbl[6] = '{2, 1'b1, 1, 2};

    // Reset state
    @(posedge clk);
    #1;
    check("rst_req", 64'(bus.fifo_r_req), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_words", 64'(bus.out_words), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(3);

    // Basic packing with fixed values
    bus.out_ready = 1'b1;
    got.delete();
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    ticks(12);
    check("basic_nbeats", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      check("basic_beat0", 64'(got[0].data), 64'h00000022_00000011);
      check("basic_words0", 64'(got[0].words), 64'd2);
      check("basic_beat1", 64'(got[1].data), 64'h00000044_00000033);
      check("basic_words1", 64'(got[1].words), 64'd2);
    end
    check("basic_req_idle", 64'(bus.fifo_r_req), 64'd0);

    // Table-driven bursts, flushed after the FIFO has drained
    for (int r = 0; r < 7; r++) begin
      got.delete();
      base = rd_ptr;
      for (int i = 0; i < tbl[r].nwords; i++) push(DW_R'(32'h100 * (r + 1) + 32'h11 * (i + 1)));
      ticks(15);
      if (tbl[r].flush) begin
        pulse_flush();
        ticks(10);
      end
      check("tbl_nbeats", 64'(got.size()), 64'(tbl[r].exp_beats));
      if (got.size() > 0) check("tbl_last_words", 64'(got[$].words), 64'(tbl[r].exp_last_words));
      check("tbl_reads", 64'(rd_ptr - base), 64'(tbl[r].nwords));
      score("tbl", base, tbl[r].flush);
    end

    // Throughput: continuous reads, one beat every 2 cycles
    got.delete(); hs_cyc.delete(); req_cyc.delete();
    base = rd_ptr;
    for (int i = 0; i < 20; i++) push(DW_R'(32'hC00 + i));
    ticks(30);
    check("tp_reads", 64'(req_cyc.size()), 64'd20);
    if (req_cyc.size() > 0) check("tp_req_contig", 64'(req_cyc[$] - req_cyc[0]), 64'd19);
    bad = 0;
    for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 2) bad++;
    check("tp_beat_spacing", 64'(bad), 64'd0);
    score("tp", base, 1'b0);

    // Backpressure: only 4 words may be drawn while the beat is held
    got.delete();
    base = rd_ptr;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW_R'(32'hB0 + i));
    ticks(10);
    check("stall_reads", 64'(rd_ptr - base), 64'd4);
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    ticks(12);
    check("stall_drained", 64'(rd_ptr), 64'(wr_ptr));
    score("stall", base, 1'b0);

    // Flush of a partial beat; reads blocked until it is emitted
    got.delete();
    base = rd_ptr;
    push(32'h11); push(32'h22); push(32'h33);
    for (int i = 0; i < 10 && rd_ptr != wr_ptr; i++) tick();
    check("fl_read3", 64'(rd_ptr - base), 64'd3);
    pulse_flush();
    push(32'h55); push(32'h66);
    r0 = req_cnt;
    t0 = req_cnt;
    for (int i = 0; i < 20 && got.size() < 2; i++) begin
      t0 = req_cnt;
      tick();
    end
    check("fl_partial_seen", 64'(got.size() >= 2), 64'd1);
    check("fl_no_req_pending", 64'(t0 - r0), 64'd0);
    if (got.size() >= 2) begin
      check("fl_beat0", 64'(got[0].data), 64'h00000022_00000011);
      check("fl_words0", 64'(got[0].words), 64'd2);
      check("fl_beat1", 64'(got[1].data), 64'h00000000_00000033);
      check("fl_words1", 64'(got[1].words), 64'd1);
    end
    ticks(10);
    check("fl_next_nbeats", 64'(got.size()), 64'd3);
    if (got.size() >= 3) check("fl_next_beat", 64'(got[2].data), 64'h00000066_00000055);

    // Flush with nothing buffered: no beat, reads resume promptly
    ticks(4);
    got.delete();
    pulse_flush();
    base = rd_ptr;
    push(32'h77);
    r0 = req_cnt;
    for (int i = 0; i < 2 && req_cnt == r0; i++) tick();
    check("fe_req_resumes", 64'(req_cnt > r0), 64'd1);
    check("fe_no_beat", 64'(got.size()), 64'd0);
    push(32'h78);
    ticks(10);
    score("fe", base, 1'b0);

    // Asynchronous reset with one word packed and one in flight
    got.delete();
    push(32'hA1);
    ticks(4);
    push(32'hA2);
    tick();
    push(32'hA3);
    p = wr_ptr - 1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 64'(bus.fifo_r_req), 64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_data", 64'(bus.out_data), 64'd0);
    check("arst_words", 64'(bus.out_words), 64'd0);
    prev_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("arst_a3_unread", 64'(rd_ptr), 64'(p));
    got.delete();
    base = rd_ptr;
    push(32'hA4);
    ticks(12);
    score("arst", base, 1'b0);
    if (got.size() > 0) check("arst_beat", 64'(got[0].data), 64'h000000A4_000000A3);

    // Randomized traffic, empty gaps and backpressure
    got.delete();
    base = rd_ptr;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(1, 0) == 1 && (wr_ptr - base) < 600) push($urandom);
      force_empty   = ($urandom_range(3, 0) == 0);
      bus.out_ready = ($urandom_range(2, 0) != 0);
      tick();
    end
    force_empty   = 1'b0;
    bus.out_ready = 1'b1;
    ticks(20);
    pulse_flush();
    ticks(20);
    check("rnd_drained", 64'(rd_ptr), 64'(wr_ptr));
    score("rnd", base, 1'b1);

    check("no_req_when_empty", 64'(bad_req), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
